// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and the parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 16;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// Producer-side valid/ready push channel into the UART transmitter.
interface uart_tx_gen_if #(
  parameter int DATA_W = 8
);
  logic              Data_Valid;
  logic [DATA_W-1:0] P_DATA;
  logic              ready;

  modport master (output Data_Valid, output P_DATA, input ready);
  modport slave  (input Data_Valid, input P_DATA, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with show-ahead read: the head word is visible on dout
// while not empty, so the transmitter can latch it on the same edge it pops.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              push_ok;
  logic              pop_ok;

  // Full/empty come from the registered count only, so a pop cannot open a slot for a same-edge push.
  assign full    = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally modulo the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter: input FIFO, per-frame latched configuration,
// programmable bit time, optional parity, one or two stop bits, back-to-back frames.
module uart_tx_gen
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  uart_tx_gen_if.slave          in_if,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  busy,
  output logic                  TX_OUT
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  uart_state_e           state_reg, state_next;
  logic [PRESCALE_W-1:0] cnt_reg, cnt_next;
  logic [BW-1:0]         bit_reg, bit_next;
  logic                  tx_reg, tx_next;
  logic [DATA_W-1:0]     shift_reg;
  logic                  parity_reg;
  logic                  par_en_reg;
  logic                  stop2_reg;
  logic [PRESCALE_W-1:0] pre_reg;
  logic                  pop;
  logic                  shift_en;
  logic                  bit_end;
  logic [DATA_W-1:0]     fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  uart_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (RST),
    .push  (in_if.Data_Valid),
    .din   (in_if.P_DATA),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_if.ready = !fifo_full;
  assign busy        = (state_reg != IDLE);
  assign TX_OUT      = tx_reg;
  assign bit_end     = (cnt_reg == pre_reg);

  // Next state, counters and the level the line takes after the coming edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    shift_en   = 1'b0;
    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + PRESCALE_W'(1);
    end
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        tx_next  = IDLE_LEVEL;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
          tx_next    = START_LEVEL;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_reg == LAST_BIT) begin
            bit_next   = '0;
            state_next = par_en_reg ? PARITY : STOP;
            tx_next    = par_en_reg ? parity_reg : IDLE_LEVEL;
          end else begin
            bit_next = bit_reg + BW'(1);
            shift_en = 1'b1;
            tx_next  = shift_reg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          bit_next   = '0;
          tx_next    = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_reg == BW'(1) || !stop2_reg) begin
            bit_next = '0;
            if (!fifo_empty) begin
              pop        = 1'b1;
              state_next = START;
              tx_next    = START_LEVEL;
            end else begin
              state_next = IDLE;
              tx_next    = IDLE_LEVEL;
            end
          end else begin
            bit_next = BW'(1);
            tx_next  = IDLE_LEVEL;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = IDLE_LEVEL;
      end
    endcase
  end

  // State, bit timer, bit index and the registered serial output.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      tx_reg    <= IDLE_LEVEL;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
    end
  end

  // Word and frame configuration are captured together at pop; the shifter walks the data LSB first.
  always_ff @(posedge clk) begin
    if (RST) begin
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      par_en_reg <= 1'b0;
      stop2_reg  <= 1'b0;
      pre_reg    <= '0;
    end else if (pop) begin
      shift_reg  <= fifo_dout;
      parity_reg <= parity_bit(PAR_MAX_W'(fifo_dout), PAR_TYP);
      par_en_reg <= PAR_EN;
      stop2_reg  <= STOP2;
      pre_reg    <= prescale;
    end else if (shift_en) begin
      shift_reg  <= shift_reg >> 1;
    end
  end

endmodule

// File: doc/uart_tx_gen.md
Name: uart_tx_gen

Overview:
Parametrised next-generation UART transmitter. Adds configurable data width, an input FIFO with valid/ready handshake, and a programmable baud prescaler. Adds a selectable one or two stop bits, and back-to-back frames with no idle gap. Sits between a parallel-data producer and the serial line, replacing the fixed-width, one-bit-per-clock transmitter.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2
PRESCALE_W, 8, width of prescale input

Ports:
clk  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
Data_Valid  input  1  producer has a word on P_DATA
P_DATA  input  DATA_W  parallel word to send
ready  output  1  FIFO can accept a word; high when FIFO not full
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
STOP2  input  1  0 = one stop bit, 1 = two stop bits
prescale  input  PRESCALE_W  clk cycles per serial bit minus 1
busy  output  1  high while a frame is on the line
TX_OUT  output  1  serial line; idle high; registered

Behaviour:
- Reset: one clk, synchronous, active-high (RST sampled on rising edge). After reset:
  - FIFO empty; state IDLE; bit and cycle counters 0.
  - TX_OUT=1, busy=0, ready=1.
- RST mid-frame: frame aborted, FIFO flushed, TX_OUT=1 on the next edge.
- Push handshake:
  - Word written when Data_Valid && ready on a rising edge.
  - Data_Valid while ready=0: word discarded, no state change.
  - Full FIFO with a simultaneous pop: the push is still refused; ready is derived from the registered count only.
- Config latch: PAR_EN, PAR_TYP, STOP2 and prescale are latched together with the popped word at frame start. Changes mid-frame are ignored until the next frame.
- Parity: XOR of the latched data for even, inverted for odd. Computed at pop.
- Bit timer: each serial bit lasts prescale+1 clk cycles. prescale=0 gives one bit per clk.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: when the FIFO is non-empty. Pop and latch happen on this edge; TX_OUT=0 and busy=1 from the next edge. Latency from accepted push to start bit on an empty FIFO in IDLE is 2 clk edges.
  - START -> DATA: after one bit time.
  - DATA: sends DATA_W bits, LSB first. Bit index runs 0..DATA_W-1. Exit after bit DATA_W-1 completes: to PARITY if PAR_EN, otherwise to STOP.
  - PARITY -> STOP: after one bit time; TX_OUT = parity bit.
  - STOP: TX_OUT=1 for 1 or 2 bit times.
    - At end with FIFO non-empty: pop, relatch and go directly to START. There is no idle cycle and busy stays 1.
    - At end with FIFO empty: go to IDLE; busy=0 from the next edge.
- Frame length in bit times: 1 + DATA_W + PAR_EN + (1 + STOP2).
- busy=1 exactly when state != IDLE.
- TX_OUT is driven from a flop and is glitch-free.
- Counters saturate only by FSM control. The bit-time counter wraps from prescale to 0 at each bit boundary.
- The FIFO pointer wraps modulo FIFO_DEPTH; count is held in log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package uart_pkg holds:
  - State enum {IDLE, START, DATA, PARITY, STOP}.
  - Constants IDLE_LEVEL=1, START_LEVEL=0.
  - Function for the parity calculation, shared with the RX side.
- One sub-module, uart_tx_fifo: synchronous FIFO with parameters DATA_W and FIFO_DEPTH and a push/pop/full/empty interface.
- FSM, bit timer and output register live in uart_tx_gen.

Test Plan:
- Basic frame, DATA_W=8, prescale=0, PAR_EN=0, STOP2=0: push 0xA5 -> TX_OUT 0,1,0,1,0,0,1,0,1,1 on consecutive clks. busy high for exactly 10 clks.
- Parity both types, push 0x07 with PAR_EN=1:
  - PAR_TYP=0 -> parity bit 1.
  - PAR_TYP=1 -> parity bit 0.
  - Frame is 11 bits.
- Prescale and two stop bits: prescale=3, STOP2=1, push 0x00 -> each bit held 4 clks, stop held 8 clks, busy high for 44 clks.
- FIFO full and back-to-back:
  - Push 5 words 0x11..0x15 on consecutive clks while idle, FIFO_DEPTH=4. The first is popped immediately, so all 5 are accepted and ready drops after the fifth.
  - A sixth push while ready=0 is dropped.
  - Five frames go out with no idle clk between them.
- Mid-frame config change: PAR_EN toggles 0->1 during frame 1 -> frame 1 has no parity bit; frame 2 has one.
- Reset mid-frame: assert RST during DATA bit 3 with 2 words queued -> TX_OUT=1, busy=0 and ready=1 next clk. Nothing transmitted afterwards.
